// File: rtl/fixed_activation_pkg.sv
// Shared types, constants and the requantise/saturate helper for the
// fixed-point hard activation pipeline.
package fixed_activation_pkg;

    typedef enum logic {
        ACT_HARDSIGMOID = 1'b0,
        ACT_HARDSWISH   = 1'b1
    } act_mode_e;

    localparam int DEFAULT_MUL_NUM   = 43;
    localparam int DEFAULT_MUL_SHIFT = 8;

    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } rs_result_t;

    // Positive shift rounds half-up while dropping fraction bits; negative shift
    // adds fraction bits exactly. Result is clamped to a signed out_w range.
    function automatic rs_result_t round_sat(input logic signed [63:0] din,
                                             input int shift,
                                             input int out_w);
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rs_result_t res;
        if (shift > 0)
            q = (din + (64'sd1 <<< (shift - 1))) >>> shift;
        else if (shift == 0)
            q = din;
        else
            q = din <<< (-shift);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        res.sat   = (q > hi) || (q < lo);
        res.value = (q > hi) ? hi : ((q < lo) ? lo : q);
        return res;
    endfunction

endpackage

// File: rtl/fixed_hard_activation_pipe_if.sv
// Stream interface of the activation pipe: producer side (data_in_0 + mode)
// and consumer side (data_out_0), each with valid/ready.
interface fixed_hard_activation_pipe_if #(
    parameter int P     = 1,
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
);
    logic                 mode;
    logic [P*IN_W-1:0]    data_in_0;
    logic                 data_in_0_valid;
    logic                 data_in_0_ready;
    logic [P*OUT_W-1:0]   data_out_0;
    logic                 data_out_0_valid;
    logic                 data_out_0_ready;

    modport master (
        output mode, data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid
    );

    modport slave (
        input  mode, data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/fixed_round_sat.sv
// Per-lane requantise (round half-up or exact left shift) and saturate,
// flagging lanes that hit the output range limits.
module fixed_round_sat
    import fixed_activation_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    rs_result_t res;

    always_comb begin
        res  = round_sat(64'(din), SHIFT, OUT_W);
        dout = res.value[OUT_W-1:0];
        sat  = res.sat;
    end

    wire unused_hi = &{1'b0, res.value[63:OUT_W]};
endmodule

// File: rtl/fixed_hard_activation_pipe.sv
// Two-stage pipelined hardsigmoid/hardswish unit with independent in/out
// fixed-point formats, valid/ready back-pressure and a saturation counter.
module fixed_hard_activation_pipe
    import fixed_activation_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int MUL_NUM                     = DEFAULT_MUL_NUM,
    parameter int MUL_SHIFT                   = DEFAULT_MUL_SHIFT,
    parameter int SAT_CNT_WIDTH               = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    fixed_hard_activation_pipe_if.slave   bus,
    output logic [SAT_CNT_WIDTH-1:0]      sat_count
);
    localparam int P   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int WI  = DATA_IN_0_PRECISION_0;
    localparam int FI  = DATA_IN_0_PRECISION_1;
    localparam int WO  = DATA_OUT_0_PRECISION_0;
    localparam int FO  = DATA_OUT_0_PRECISION_1;
    localparam int HW  = WI + 2;
    localparam int PRW = WI + 34;
    localparam int RW  = WI + HW;
    localparam int CW  = $clog2(P + 1);
    localparam int SW  = SAT_CNT_WIDTH + CW + 1;

    localparam logic signed [PRW-1:0] MUL_C   = PRW'(MUL_NUM);
    localparam logic signed [PRW-1:0] HALF_M  = PRW'(2 ** (MUL_SHIFT - 1));
    localparam logic signed [PRW-1:0] HALF_FI = PRW'(2 ** (FI - 1));
    localparam logic signed [PRW-1:0] TH      = PRW'(3 * (2 ** FI));
    localparam logic signed [HW-1:0]  H_ONE   = HW'(2 ** FI);

    logic en1, en2;
    logic vld_p1, vld_p2;

    logic signed [WI-1:0]  x_p0    [P];
    logic signed [PRW-1:0] prod_p0 [P];
    logic signed [HW-1:0]  h_p0    [P];

    logic signed [WI-1:0]  x_p1    [P];
    logic signed [HW-1:0]  h_p1    [P];
    act_mode_e             mode_p1;
    logic signed [RW-1:0]  r_p1    [P];
    logic signed [WO-1:0]  q_p1    [P];
    logic [P-1:0]          sat_p1;
    logic [P*WO-1:0]       q_flat_p1;
    logic [CW-1:0]         n_sat_p1;
    logic [SW-1:0]         cnt_sum_p1;
    logic [SAT_CNT_WIDTH-1:0] cnt_next_p1;

    logic [P*WO-1:0]       out_p2;

    assign en2                 = !vld_p2 || bus.data_out_0_ready;
    assign en1                 = !vld_p1 || en2;
    assign bus.data_in_0_ready = en1;

    // ---- stage 0 -> 1: hardsigmoid in input format ----
    always_comb begin
        for (int i = 0; i < P; i++) begin
            x_p0[i]    = $signed(bus.data_in_0[i*WI +: WI]);
            prod_p0[i] = PRW'(x_p0[i]) * MUL_C;
            if (PRW'(x_p0[i]) <= -TH)
                h_p0[i] = '0;
            else if (PRW'(x_p0[i]) >= TH)
                h_p0[i] = H_ONE;
            else
                h_p0[i] = HW'(((prod_p0[i] + HALF_M) >>> MUL_SHIFT) + HALF_FI);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            vld_p1 <= 1'b0;
        else if (en1)
            vld_p1 <= bus.data_in_0_valid;
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            x_p1    <= x_p0;
            h_p1    <= h_p0;
            mode_p1 <= act_mode_e'(bus.mode);
        end
    end

    // ---- stage 1 -> 2: select, requantise, saturate ----
    // h is pre-scaled to 2*FI fraction bits so both modes share one requantiser.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            if (mode_p1 == ACT_HARDSWISH)
                r_p1[i] = RW'(x_p1[i]) * RW'(h_p1[i]);
            else
                r_p1[i] = RW'(h_p1[i]) <<< FI;
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_lane
        fixed_round_sat #(
            .IN_W (RW),
            .OUT_W(WO),
            .SHIFT(2 * FI - FO)
        ) u_round_sat (
            .din (r_p1[g]),
            .dout(q_p1[g]),
            .sat (sat_p1[g])
        );
    end

    always_comb begin
        q_flat_p1 = '0;
        n_sat_p1  = '0;
        for (int i = 0; i < P; i++) begin
            q_flat_p1[i*WO +: WO] = q_p1[i];
            n_sat_p1              = n_sat_p1 + CW'(sat_p1[i]);
        end
        cnt_sum_p1  = SW'(sat_count) + SW'(n_sat_p1);
        cnt_next_p1 = (cnt_sum_p1 > SW'({SAT_CNT_WIDTH{1'b1}})) ? '1
                                                                : cnt_sum_p1[SAT_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p2    <= 1'b0;
            out_p2    <= '0;
            sat_count <= '0;
        end else if (en2) begin
            vld_p2 <= vld_p1;
            out_p2 <= q_flat_p1;
            if (vld_p1)
                sat_count <= cnt_next_p1;
        end
    end

    assign bus.data_out_0       = out_p2;
    assign bus.data_out_0_valid = vld_p2;
endmodule

// File: tb/tb_fixed_hard_activation_pipe.sv
// Bench for fixed_hard_activation_pipe: table vectors, saturation counting,
// randomized back-pressure streams against a reference model, mid-stream reset.
module tb_fixed_hard_activation_pipe;
    localparam int FI = 4;
    localparam int FO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_hard_activation_pipe_if #(.P(1), .IN_W(8), .OUT_W(8)) ifa ();
    fixed_hard_activation_pipe_if #(.P(1), .IN_W(8), .OUT_W(6)) ifb ();
    fixed_hard_activation_pipe_if #(.P(1), .IN_W(8), .OUT_W(6)) ifc ();
    fixed_hard_activation_pipe_if #(.P(4), .IN_W(8), .OUT_W(8)) ifd ();

    logic [15:0] sat_a, sat_b, sat_d;
    logic [1:0]  sat_c;

    fixed_hard_activation_pipe dut_a (.clk(clk), .rst(rst), .bus(ifa), .sat_count(sat_a));
    fixed_hard_activation_pipe #(.DATA_OUT_0_PRECISION_0(6)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .sat_count(sat_b));
    fixed_hard_activation_pipe #(.DATA_OUT_0_PRECISION_0(6), .SAT_CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc), .sat_count(sat_c));
    fixed_hard_activation_pipe #(.DATA_IN_0_PARALLELISM_DIM_0(4)) dut_d (
        .clk(clk), .rst(rst), .bus(ifd), .sat_count(sat_d));

    assign ifc.mode             = ifb.mode;
    assign ifc.data_in_0        = ifb.data_in_0;
    assign ifc.data_in_0_valid  = ifb.data_in_0_valid;
    assign ifc.data_out_0_ready = ifb.data_out_0_ready;

    int checks   = 0;
    int failures = 0;
    int exp_sat_a = 0;
    int exp_sat_d = 0;

    typedef struct { bit m; int x; int y; } vec_t;
    typedef struct { int y[4]; int nsat; } beat_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: hardsigmoid/hardswish from the plain arithmetic rules.
    function automatic int model(input int x, input bit m, input int wo, output bit sat);
        longint h, r, q, hi, lo;
        int s;
        if (x <= -3 * (1 << FI))     h = 0;
        else if (x >= 3 * (1 << FI)) h = 1 << FI;
        else h = ((longint'(x) * 43 + 128) >>> 8) + (1 << (FI - 1));
        if (m) begin r = longint'(x) * h; s = 2 * FI - FO; end
        else   begin r = h;               s = FI - FO;     end
        if (s > 0)      q = (r + (longint'(1) << (s - 1))) >>> s;
        else if (s < 0) q = r <<< (-s);
        else            q = r;
        hi  = (longint'(1) << (wo - 1)) - 1;
        lo  = -(longint'(1) << (wo - 1));
        sat = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    task automatic drive(input int sel, input bit v, input bit m, input int lanes[4], input bit ordy);
        if (sel == 0) begin
            ifa.data_in_0_valid  = v;
            ifa.mode             = m;
            ifa.data_in_0        = 8'(lanes[0]);
            ifa.data_out_0_ready = ordy;
        end else begin
            ifd.data_in_0_valid  = v;
            ifd.mode             = m;
            for (int l = 0; l < 4; l++) ifd.data_in_0[l*8 +: 8] = 8'(lanes[l]);
            ifd.data_out_0_ready = ordy;
        end
    endtask

    task automatic sample(input int sel, output bit ov, output int od[4], output bit ir, output int sc);
        for (int l = 0; l < 4; l++) od[l] = 0;
        if (sel == 0) begin
            ov    = ifa.data_out_0_valid;
            od[0] = int'($signed(ifa.data_out_0));
            ir    = ifa.data_in_0_ready;
            sc    = int'(sat_a);
        end else begin
            ov = ifd.data_out_0_valid;
            for (int l = 0; l < 4; l++) od[l] = int'($signed(ifd.data_out_0[l*8 +: 8]));
            ir = ifd.data_in_0_ready;
            sc = int'(sat_d);
        end
    endtask

    task automatic run_stream(input int sel, input int nb, input bit alt);
        beat_t q[$];
        beat_t cur, e;
        bit pending = 0, prev_stall = 0, m = 0, ov, ir, ordy, s;
        int sent = 0, popped = 0, inflight = 0, sc, nl;
        int lanes[4], od[4], prev_od[4];
        nl = (sel == 0) ? 1 : 4;
        for (int l = 0; l < 4; l++) begin lanes[l] = 0; prev_od[l] = 0; end
        for (int cyc = 0; cyc < 600 && popped < nb; cyc++) begin
            @(negedge clk);
            sample(sel, ov, od, ir, sc);
            if (prev_stall) begin
                chk("hold_valid", ov, 1);
                for (int l = 0; l < nl; l++) chk("hold_data", od[l], prev_od[l]);
            end
            ordy = 1'($urandom_range(0, 1));
            if (!pending && sent < nb && $urandom_range(0, 3) != 0) begin
                m = alt ? 1'(sent % 2) : 1'($urandom_range(0, 1));
                cur.nsat = 0;
                for (int l = 0; l < 4; l++) begin
                    lanes[l] = int'($urandom_range(0, 255)) - 128;
                    cur.y[l] = model(lanes[l], m, 8, s);
                    if (l < nl && s) cur.nsat++;
                end
                pending = 1;
            end
            drive(sel, pending, m, lanes, ordy);
            #1;
            sample(sel, ov, od, ir, sc);
            chk("in_ready", ir, !(inflight == 2 && !ordy));
            if (ov && ordy) begin
                chk("beat_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    for (int l = 0; l < nl; l++) chk("stream_data", od[l], e.y[l]);
                    popped++;
                    inflight--;
                end
            end
            if (pending && ir) begin
                q.push_back(cur);
                sent++;
                inflight++;
                pending = 0;
                if (sel == 0) exp_sat_a += cur.nsat;
                else          exp_sat_d += cur.nsat;
            end
            prev_stall = ov && !ordy;
            prev_od    = od;
        end
        chk("stream_done", popped, nb);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, lanes, 1'b1);
        sample(sel, ov, od, ir, sc);
        chk("stream_sat_count", sc, (sel == 0) ? exp_sat_a : exp_sat_d);
    endtask

    initial begin
        int idx;
        vecs = '{'{1'b0, 16, 11}, '{1'b0, 0, 8}, '{1'b0, -48, 0}, '{1'b0, 48, 16},
                 '{1'b0, -128, 0}, '{1'b0, 127, 16},
                 '{1'b1, 16, 11}, '{1'b1, 32, 26}, '{1'b1, 48, 48}, '{1'b1, -48, 0}};
        ifa.mode = 0; ifa.data_in_0 = '0; ifa.data_in_0_valid = 0; ifa.data_out_0_ready = 1;
        ifb.mode = 0; ifb.data_in_0 = '0; ifb.data_in_0_valid = 0; ifb.data_out_0_ready = 1;
        ifd.mode = 0; ifd.data_in_0 = '0; ifd.data_in_0_valid = 0; ifd.data_out_0_ready = 1;
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid_a", ifa.data_out_0_valid, 0);
        chk("rst_data_a", ifa.data_out_0, 0);
        chk("rst_sat_a", sat_a, 0);
        chk("rst_ready_a", ifa.data_in_0_ready, 1);
        chk("rst_valid_d", ifd.data_out_0_valid, 0);
        chk("rst_data_d", ifd.data_out_0, 0);
        rst = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            ifa.mode = vecs[i].m; ifa.data_in_0 = 8'(vecs[i].x); ifa.data_in_0_valid = 1;
            #1 chk("vec_in_ready", ifa.data_in_0_ready, 1);
            @(negedge clk);
            ifa.data_in_0_valid = 0;
            chk("vec_valid_1cyc", ifa.data_out_0_valid, 0);
            @(negedge clk);
            chk("vec_valid_2cyc", ifa.data_out_0_valid, 1);
            chk("vec_data", int'($signed(ifa.data_out_0)), vecs[i].y);
            chk("vec_sat_count", sat_a, 0);
        end

        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (ifb.data_out_0_valid) begin
                idx++;
                chk("sat_data", int'($signed(ifb.data_out_0)), 31);
                chk("sat_count_16b", sat_b, idx);
                chk("sat_count_2b", sat_c, (idx < 3) ? idx : 3);
            end
            ifb.mode = 1; ifb.data_in_0 = 8'd127; ifb.data_in_0_valid = (cyc < 11);
        end
        chk("sat_beats", idx, 11);

        run_stream(0, 20, 1'b0);
        run_stream(1, 20, 1'b1);

        @(negedge clk);
        ifa.data_out_0_ready = 0; ifa.mode = 0; ifa.data_in_0 = 8'd16; ifa.data_in_0_valid = 1;
        @(negedge clk);
        ifa.data_in_0 = 8'd32;
        @(negedge clk);
        ifa.data_in_0_valid = 0;
        #1 chk("full_ready_low", ifa.data_in_0_ready, 0);
        chk("full_valid", ifa.data_out_0_valid, 1);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("mid_rst_valid", ifa.data_out_0_valid, 0);
        chk("mid_rst_data", ifa.data_out_0, 0);
        chk("mid_rst_sat", sat_a, 0);
        #1 chk("mid_rst_ready", ifa.data_in_0_ready, 1);
        ifa.data_out_0_ready = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_beat", ifa.data_out_0_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
